// File: rtl/alphabet_tap_sequencer.sv
// alphabet_tap_sequencer
// Replays a 5-bit letter code (1=a .. 26=z) as multi-tap keypad activity:
// the key is loaded on accept, press pulses once per tap with timed gaps,
// then commit pulses with {key, tap} equal to the pair that encodes back
// to the accepted letter. Illegal codes are accepted and flagged with err.
// Optional feature: define ALPHA_TAP_LETTER_COUNT_EN to add an 8-bit
// letter_cnt output that counts committed letters (wraps 255 -> 0).
module alphabet_tap_sequencer #(
  parameter int PRESS_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int HOLD_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] alphabet,
  output logic [3:0] key,
  output logic [1:0] tap,
  output logic       press,
  output logic       commit,
  output logic       err
`ifdef ALPHA_TAP_LETTER_COUNT_EN
  ,
  output logic [7:0] letter_cnt
`endif
);

  // Timer counts down from (duration - 1), so it only needs to reach the
  // largest duration minus one; it is never allowed to wrap.
  localparam int MAX_CYCLES_A = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int MAX_CYCLES   = (MAX_CYCLES_A > HOLD_CYCLES) ? MAX_CYCLES_A : HOLD_CYCLES;
  localparam int TW           = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] T_ZERO  = TW'(0);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_PRESS = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRESS = 3'd1,
    S_GAP   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Letter code -> {legal, key[3:0], last tap index[1:0]}.
  function automatic logic [6:0] decode_letter(input logic [4:0] code);
    logic [6:0] res;
    case (code)
      5'd1:    res = {1'b1, 4'd2, 2'd0};
      5'd2:    res = {1'b1, 4'd2, 2'd1};
      5'd3:    res = {1'b1, 4'd2, 2'd2};
      5'd4:    res = {1'b1, 4'd3, 2'd0};
      5'd5:    res = {1'b1, 4'd3, 2'd1};
      5'd6:    res = {1'b1, 4'd3, 2'd2};
      5'd7:    res = {1'b1, 4'd4, 2'd0};
      5'd8:    res = {1'b1, 4'd4, 2'd1};
      5'd9:    res = {1'b1, 4'd4, 2'd2};
      5'd10:   res = {1'b1, 4'd5, 2'd0};
      5'd11:   res = {1'b1, 4'd5, 2'd1};
      5'd12:   res = {1'b1, 4'd5, 2'd2};
      5'd13:   res = {1'b1, 4'd6, 2'd0};
      5'd14:   res = {1'b1, 4'd6, 2'd1};
      5'd15:   res = {1'b1, 4'd6, 2'd2};
      5'd16:   res = {1'b1, 4'd7, 2'd0};
      5'd17:   res = {1'b1, 4'd7, 2'd1};
      5'd18:   res = {1'b1, 4'd7, 2'd2};
      5'd19:   res = {1'b1, 4'd7, 2'd3};
      5'd20:   res = {1'b1, 4'd8, 2'd0};
      5'd21:   res = {1'b1, 4'd8, 2'd1};
      5'd22:   res = {1'b1, 4'd8, 2'd2};
      5'd23:   res = {1'b1, 4'd9, 2'd0};
      5'd24:   res = {1'b1, 4'd9, 2'd1};
      5'd25:   res = {1'b1, 4'd9, 2'd2};
      5'd26:   res = {1'b1, 4'd9, 2'd3};
      default: res = 7'd0;
    endcase
    return res;
  endfunction

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [1:0]    tgt_r;
  logic [3:0]    key_r;
  logic [1:0]    tap_r;
  logic          press_r;
  logic          commit_r;
  logic          err_r;
  logic          in_ready_r;
  logic [7:0]    letter_cnt_r;

  logic [6:0]    decode_s;
  logic          legal_s;
  logic [3:0]    key_s;
  logic [1:0]    tgt_s;

  // Combinational decode of the offered letter code.
  always_comb begin
    decode_s = decode_letter(alphabet);
    legal_s  = decode_s[6];
    key_s    = decode_s[5:2];
    tgt_s    = decode_s[1:0];
  end

  // Sequencer FSM: timers, tap counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      timer_r      <= T_ZERO;
      tgt_r        <= 2'd0;
      key_r        <= 4'd0;
      tap_r        <= 2'd0;
      press_r      <= 1'b0;
      commit_r     <= 1'b0;
      err_r        <= 1'b0;
      in_ready_r   <= 1'b1;
      letter_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_r <= 1'b0;
            if (legal_s) begin
              key_r   <= key_s;
              tgt_r   <= tgt_s;
              tap_r   <= 2'd0;
              press_r <= 1'b1;
              timer_r <= T_PRESS;
              state_r <= S_PRESS;
            end else begin
              err_r   <= 1'b1;
              state_r <= S_ERR;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        S_PRESS: begin
          if (timer_r == T_ZERO) begin
            press_r <= 1'b0;
            timer_r <= T_GAP;
            state_r <= S_GAP;
          end else begin
            timer_r <= timer_r - T_ONE;
          end
        end
        S_GAP: begin
          if (timer_r == T_ZERO) begin
            if (tap_r != tgt_r) begin
              tap_r   <= tap_r + 2'd1;
              press_r <= 1'b1;
              timer_r <= T_PRESS;
              state_r <= S_PRESS;
            end else begin
              timer_r <= T_HOLD;
              state_r <= S_HOLD;
            end
          end else begin
            timer_r <= timer_r - T_ONE;
          end
        end
        S_HOLD: begin
          if (timer_r == T_ZERO) begin
            commit_r <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            timer_r <= timer_r - T_ONE;
          end
        end
        S_DONE: begin
          commit_r     <= 1'b0;
          in_ready_r   <= 1'b1;
          letter_cnt_r <= letter_cnt_r + 8'd1;
          state_r      <= S_IDLE;
        end
        S_ERR: begin
          err_r      <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          // Unreachable encoding: fall back to a quiet idle state.
          state_r    <= S_IDLE;
          timer_r    <= T_ZERO;
          press_r    <= 1'b0;
          commit_r   <= 1'b0;
          err_r      <= 1'b0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_r;
  assign key      = key_r;
  assign tap      = tap_r;
  assign press    = press_r;
  assign commit   = commit_r;
  assign err      = err_r;

`ifdef ALPHA_TAP_LETTER_COUNT_EN
  assign letter_cnt = letter_cnt_r;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = ^letter_cnt_r;
`endif

endmodule

// File: tb/tb_alphabet_tap_sequencer.sv
// Self-checking bench for alphabet_tap_sequencer (P=2, G=2, H=3).
// Expected activity for each accepted code is queued at accept and checked
// cycle by cycle on the falling edge until its commit or err completes.
module tb_alphabet_tap_sequencer;

  localparam int P = 2;
  localparam int G = 2;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] alphabet = 5'd0;
  logic [3:0] key;
  logic [1:0] tap;
  logic       press;
  logic       commit;
  logic       err;
`ifdef ALPHA_TAP_LETTER_COUNT_EN
  logic [7:0] letter_cnt;
`endif

  alphabet_tap_sequencer #(.PRESS_CYCLES(P), .GAP_CYCLES(G), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alphabet(alphabet), .key(key), .tap(tap), .press(press),
    .commit(commit), .err(err)
`ifdef ALPHA_TAP_LETTER_COUNT_EN
    , .letter_cnt(letter_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    bit legal;
    int k;
    int t;
    int n;
    int acc;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    fails = 0;
  int    negcnt = 0;
  bit    checking = 1'b0;
  int    exp_key = 0;
  int    last_tap = 0;
  int    exp_cnt = 0;
  string keys = "22233344455566677778889999";

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", name, got, expv, negcnt);
    end
  endtask

  // Keypad digit of a letter, taken from the printed keypad layout.
  function automatic int key_of(int code);
    byte c;
    c = keys[code-1];
    return int'(c) - 48;
  endfunction

  // Tap index = number of earlier letters on the same key.
  function automatic int tap_of(int code);
    int cnt = 0;
    for (int i = 0; i < code - 1; i++)
      if (keys[i] == keys[code-1]) cnt++;
    return cnt;
  endfunction

  // Multi-tap encoder: first letter on the key plus the tap index.
  function automatic int encode(int k, int t);
    for (int i = 0; i < 26; i++) begin
      byte c;
      c = keys[i];
      if (int'(c) - 48 == k) return i + 1 + t;
    end
    return 0;
  endfunction

  // Per-cycle monitor comparing DUT outputs with the queued expectation.
  always @(negedge clk) begin
    int rel, k, ep, et, cc;
    negcnt++;
    if (checking) begin
      if (sb.size() == 0) begin
        check("idle_ready", in_ready, 1);
        check("idle_press", press, 0);
        check("idle_commit", commit, 0);
        check("idle_err", err, 0);
        check("idle_key", key, exp_key);
        check("idle_tap", tap, last_tap);
      end else begin
        rel = negcnt - sb[0].acc;
        check("busy_ready", in_ready, 0);
        check("key", key, exp_key);
        if (!sb[0].legal) begin
          check("err_pulse", err, (rel == 1) ? 1 : 0);
          check("err_press", press, 0);
          check("err_commit", commit, 0);
          check("err_tap", tap, last_tap);
          if (rel >= 1) void'(sb.pop_front());
        end else begin
          cc = sb[0].n * (P + G) + H + 1;
          ep = (rel >= 1 && rel <= sb[0].n * (P + G) && ((rel - 1) % (P + G)) < P) ? 1 : 0;
          k = (rel - 1) / (P + G);
          if (k > sb[0].n - 1) k = sb[0].n - 1;
          et = k;
          check("press", press, ep);
          check("tap", tap, et);
          check("err_quiet", err, 0);
          check("commit", commit, (rel == cc) ? 1 : 0);
          if (commit === 1'b1 || rel >= cc) begin
            check("commit_tap", tap, sb[0].t);
            check("encode", encode(int'(key), int'(tap)), sb[0].code);
            last_tap = sb[0].t;
            exp_cnt++;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int code, output int acc);
    item_t it;
    int w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", in_ready, 1);
    #1;
    in_valid = 1'b1;
    alphabet = 5'(code);
    @(posedge clk);
    acc = negcnt;
    it.code  = code;
    it.legal = (code >= 1 && code <= 26);
    it.k     = it.legal ? key_of(code) : 0;
    it.t     = it.legal ? tap_of(code) : 0;
    it.n     = it.t + 1;
    it.acc   = acc;
    if (it.legal) exp_key = it.k;
    sb.push_back(it);
    #1;
    in_valid = 1'b0;
    alphabet = 5'd0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(1, acc);  drain();   // a
    send(3, acc);  drain();   // c
    send(19, acc); drain();   // s
    send(26, acc); drain();   // z
    send(0, acc);  drain();   // illegal 0
    send(27, acc); drain();   // illegal 27

    // Reset during the second press of 'e'.
    send(5, acc);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    exp_key = 0;
    last_tap = 0;
    exp_cnt = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;

    send(2, acc);  drain();   // b after reset

    for (int c = 1; c <= 26; c++) send(c, acc);
    drain();
    send(31, acc); drain();   // illegal 31 after the sweep

`ifdef ALPHA_TAP_LETTER_COUNT_EN
    check("letter_cnt", letter_cnt, exp_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
